// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: display > {CPU, command}, one outstanding transaction.
// Define VDP_VRAM_ARB_ROUND_ROBIN_EN to alternate CPU/command; otherwise CPU beats command.
module vdp_vram_arbiter #(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dsp_req,
    input  logic              cpu_req,
    input  logic              cmd_req,
    input  logic [ADDR_W-1:0] dsp_address,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic              cpu_write,
    input  logic              cmd_write,
    input  logic [7:0]        cpu_wdata,
    input  logic [7:0]        cmd_wdata,
    output logic              dsp_ack,
    output logic              cpu_ack,
    output logic              cmd_ack,
    output logic              dsp_rdata_en,
    output logic              cpu_rdata_en,
    output logic              cmd_rdata_en,
    output logic [31:0]       rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rdata_en
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ} state_t;
    localparam logic [1:0] OWN_DSP = 2'd0, OWN_CPU = 2'd1, OWN_CMD = 2'd2;

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              pick_cmd, issue_fire, read_fire;

`ifdef VDP_VRAM_ARB_ROUND_ROBIN_EN
    // rr_q = 0 favours CPU, 1 favours command; only consulted when both request.
    logic rr_q, rr_d;
    assign pick_cmd = cmd_req && (!cpu_req || rr_q);

    always_comb begin
        rr_d = rr_q;
        if (issue_fire && owner_q == OWN_CPU) rr_d = 1'b1;
        if (issue_fire && owner_q == OWN_CMD) rr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end
`else
    assign pick_cmd = cmd_req && !cpu_req;
`endif

    assign issue_fire = (state_q == ISSUE) && mem_ready;
    assign read_fire  = (state_q == WAIT_READ) && mem_rdata_en;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (dsp_req) begin
                    owner_d = OWN_DSP;
                    write_d = 1'b0;
                    addr_d  = dsp_address;
                    wdata_d = 8'h00;
                end else if (pick_cmd) begin
                    owner_d = OWN_CMD;
                    write_d = cmd_write;
                    addr_d  = cmd_address;
                    wdata_d = cmd_wdata;
                end else if (cpu_req) begin
                    owner_d = OWN_CPU;
                    write_d = cpu_write;
                    addr_d  = cpu_address;
                    wdata_d = cpu_wdata;
                end
                if (dsp_req || cpu_req || cmd_req) state_d = ISSUE;
            end
            ISSUE: begin
                if (mem_ready) state_d = write_q ? IDLE : WAIT_READ;
            end
            WAIT_READ: begin
                if (mem_rdata_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_DSP;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Acks and read strobes are gated by the live handshake so they land in the same cycle.
    assign mem_valid    = (state_q == ISSUE);
    assign mem_write    = write_q;
    assign mem_address  = addr_q;
    assign mem_wdata    = wdata_q;
    assign dsp_ack      = issue_fire && (owner_q == OWN_DSP);
    assign cpu_ack      = issue_fire && (owner_q == OWN_CPU);
    assign cmd_ack      = issue_fire && (owner_q == OWN_CMD);
    assign dsp_rdata_en = read_fire && (owner_q == OWN_DSP);
    assign cpu_rdata_en = read_fire && (owner_q == OWN_CPU);
    assign cmd_rdata_en = read_fire && (owner_q == OWN_CMD);
    assign rdata        = read_fire ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_vdp_vram_arbiter;
    localparam logic [17:0] DSP_A = 18'h00100, CPU_A = 18'h3F000, CMD_A = 18'h10000;

    logic        clk = 1'b0, reset = 1'b1;
    logic        dsp_req = 0, cpu_req = 0, cmd_req = 0;
    logic [17:0] dsp_address = DSP_A, cpu_address = CPU_A, cmd_address = CMD_A;
    logic        cpu_write = 0, cmd_write = 0;
    logic [7:0]  cpu_wdata = 8'hA5, cmd_wdata = 8'h5A;
    logic        dsp_ack, cpu_ack, cmd_ack, dsp_rdata_en, cpu_rdata_en, cmd_rdata_en;
    logic [31:0] rdata;
    logic        mem_valid, mem_ready = 0, mem_write;
    logic [17:0] mem_address;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic        mem_rdata_en = 0;

    vdp_vram_arbiter #(.ADDR_W(18)) dut (
        .clk(clk), .reset(reset),
        .dsp_req(dsp_req), .cpu_req(cpu_req), .cmd_req(cmd_req),
        .dsp_address(dsp_address), .cpu_address(cpu_address), .cmd_address(cmd_address),
        .cpu_write(cpu_write), .cmd_write(cmd_write), .cpu_wdata(cpu_wdata), .cmd_wdata(cmd_wdata),
        .dsp_ack(dsp_ack), .cpu_ack(cpu_ack), .cmd_ack(cmd_ack),
        .dsp_rdata_en(dsp_rdata_en), .cpu_rdata_en(cpu_rdata_en), .cmd_rdata_en(cmd_rdata_en),
        .rdata(rdata), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rdata_en(mem_rdata_en)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, wanted %h", nm, act, exp);
        end
    endtask

    // req = {dsp, cpu, cmd}; wr = {cpu, cmd}; ack/ren = {dsp, cpu, cmd}
    typedef struct {
        logic [2:0]  req;
        logic [1:0]  wr;
        logic        rdy;
        logic        ri;
        logic [31:0] rd;
        logic        vld;
        logic        wo;
        logic [17:0] addr;
        logic [7:0]  wd;
        logic [2:0]  ack;
        logic [2:0]  ren;
        logic [31:0] rdat;
    } vec_t;

    function automatic vec_t mk(logic [2:0] req, logic [1:0] wr, logic rdy, logic ri,
                                logic [31:0] rd, logic vld, logic wo, logic [17:0] addr,
                                logic [7:0] wd, logic [2:0] ack, logic [2:0] ren,
                                logic [31:0] rdat);
        vec_t v;
        v.req = req; v.wr = wr; v.rdy = rdy; v.ri = ri; v.rd = rd;
        v.vld = vld; v.wo = wo; v.addr = addr; v.wd = wd; v.ack = ack; v.ren = ren; v.rdat = rdat;
        return v;
    endfunction

    task automatic drive(input logic [2:0] req, input logic [1:0] wr, input logic rdy,
                         input logic ri, input logic [31:0] rd);
        {dsp_req, cpu_req, cmd_req} = req;
        {cpu_write, cmd_write} = wr;
        mem_ready = rdy; mem_rdata_en = ri; mem_rdata = rd;
    endtask

    task automatic do_reset();
        drive(3'b000, 2'b00, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tbl[18];
    int   grants[$];
    int   n_ack, n_cmd;

    initial begin
        tbl[0]  = mk(3'b000, 2'b00, 0, 0, 32'h0,        0, 0, 18'h0, 8'h00, 3'b000, 3'b000, 32'h0);
        tbl[1]  = mk(3'b010, 2'b10, 1, 0, 32'h0,        0, 0, 18'h0, 8'h00, 3'b000, 3'b000, 32'h0);
        tbl[2]  = mk(3'b010, 2'b10, 1, 0, 32'h0,        1, 1, CPU_A, 8'hA5, 3'b010, 3'b000, 32'h0);
        tbl[3]  = mk(3'b000, 2'b00, 0, 0, 32'h0,        0, 0, 18'h0, 8'h00, 3'b000, 3'b000, 32'h0);
        tbl[4]  = mk(3'b001, 2'b00, 0, 1, 32'hDEADBEEF, 0, 0, 18'h0, 8'h00, 3'b000, 3'b000, 32'h0);
        tbl[5]  = mk(3'b001, 2'b00, 0, 0, 32'h0,        1, 0, CMD_A, 8'h00, 3'b000, 3'b000, 32'h0);
        tbl[6]  = mk(3'b001, 2'b00, 0, 1, 32'h11111111, 1, 0, CMD_A, 8'h00, 3'b000, 3'b000, 32'h0);
        tbl[7]  = mk(3'b001, 2'b00, 1, 0, 32'h0,        1, 0, CMD_A, 8'h00, 3'b001, 3'b000, 32'h0);
        tbl[8]  = mk(3'b010, 2'b10, 1, 0, 32'h0,        0, 0, 18'h0, 8'h00, 3'b000, 3'b000, 32'h0);
        tbl[9]  = mk(3'b010, 2'b10, 1, 1, 32'h03020100, 0, 0, 18'h0, 8'h00, 3'b000, 3'b001, 32'h03020100);
        tbl[10] = mk(3'b010, 2'b10, 1, 1, 32'h00000055, 0, 0, 18'h0, 8'h00, 3'b000, 3'b000, 32'h0);
        tbl[11] = mk(3'b010, 2'b10, 1, 0, 32'h0,        1, 1, CPU_A, 8'hA5, 3'b010, 3'b000, 32'h0);
        tbl[12] = mk(3'b110, 2'b10, 1, 0, 32'h0,        0, 0, 18'h0, 8'h00, 3'b000, 3'b000, 32'h0);
        tbl[13] = mk(3'b110, 2'b10, 1, 0, 32'h0,        1, 0, DSP_A, 8'h00, 3'b100, 3'b000, 32'h0);
        tbl[14] = mk(3'b010, 2'b10, 1, 1, 32'hCAFEF00D, 0, 0, 18'h0, 8'h00, 3'b000, 3'b100, 32'hCAFEF00D);
        tbl[15] = mk(3'b010, 2'b10, 1, 0, 32'h0,        0, 0, 18'h0, 8'h00, 3'b000, 3'b000, 32'h0);
        tbl[16] = mk(3'b010, 2'b10, 1, 0, 32'h0,        1, 1, CPU_A, 8'hA5, 3'b010, 3'b000, 32'h0);
        tbl[17] = mk(3'b000, 2'b00, 1, 0, 32'h0,        0, 0, 18'h0, 8'h00, 3'b000, 3'b000, 32'h0);

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Per-cycle table; inputs change at negedge, outputs sampled 3 ns later.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].req, tbl[i].wr, tbl[i].rdy, tbl[i].ri, tbl[i].rd);
            #3;
            chk($sformatf("row%0d mem_valid", i), 32'(mem_valid), 32'(tbl[i].vld));
            chk($sformatf("row%0d ack", i), 32'({dsp_ack, cpu_ack, cmd_ack}), 32'(tbl[i].ack));
            chk($sformatf("row%0d rdata_en", i),
                32'({dsp_rdata_en, cpu_rdata_en, cmd_rdata_en}), 32'(tbl[i].ren));
            chk($sformatf("row%0d rdata", i), rdata, tbl[i].rdat);
            if (tbl[i].vld || i == 0) begin
                chk($sformatf("row%0d mem_address", i), 32'(mem_address), 32'(tbl[i].addr));
                chk($sformatf("row%0d mem_write", i), 32'(mem_write), 32'(tbl[i].wo));
            end
            if ((tbl[i].vld && tbl[i].wo) || i == 0)
                chk($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].wd));
            @(negedge clk);
        end

        // Back-to-back CPU writes of 0x00 to 0x3F000 with mem_ready tied high.
        cpu_wdata = 8'h00;
        n_ack = 0;
        for (int k = 0; k < 8; k++) begin
            drive(3'b010, 2'b10, 1'b1, 1'b0, 32'h0);
            #3;
            chk($sformatf("b2b%0d mem_valid", k), 32'(mem_valid), 32'(k % 2));
            chk($sformatf("b2b%0d cpu_ack", k), 32'(cpu_ack), 32'(k % 2));
            if (k % 2 == 1) begin
                chk($sformatf("b2b%0d mem_address", k), 32'(mem_address), 32'(CPU_A));
                chk($sformatf("b2b%0d mem_wdata", k), 32'(mem_wdata), 32'h00);
            end
            if (cpu_ack) n_ack++;
            @(negedge clk);
        end
        chk("b2b ack count", 32'(n_ack), 32'd4);
        cpu_wdata = 8'hA5;

        // Command read with data returned 5 cycles after ack.
        drive(3'b001, 2'b00, 1'b1, 1'b0, 32'h0);
        #3; chk("rd latch valid", 32'(mem_valid), 32'd0);
        @(negedge clk); #3;
        chk("rd ack", 32'({dsp_ack, cpu_ack, cmd_ack}), 32'b001);
        @(negedge clk);
        drive(3'b000, 2'b00, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #3;
            chk($sformatf("rd wait%0d rdata_en", k),
                32'({dsp_rdata_en, cpu_rdata_en, cmd_rdata_en}), 32'b000);
            chk($sformatf("rd wait%0d mem_valid", k), 32'(mem_valid), 32'd0);
            @(negedge clk);
        end
        drive(3'b000, 2'b00, 1'b1, 1'b1, 32'h03020100);
        #3;
        chk("rd return rdata_en", 32'({dsp_rdata_en, cpu_rdata_en, cmd_rdata_en}), 32'b001);
        chk("rd return rdata", rdata, 32'h03020100);
        @(negedge clk);
        drive(3'b000, 2'b00, 1'b1, 1'b0, 32'h0);
        #3; chk("rd after rdata_en", 32'(cmd_rdata_en), 32'd0);
        @(negedge clk);

        // Backpressure: mem_ready held low for 10 ISSUE cycles.
        drive(3'b001, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            #3;
            chk($sformatf("bp%0d mem_valid", k), 32'(mem_valid), 32'd1);
            chk($sformatf("bp%0d mem_address", k), 32'(mem_address), 32'(CMD_A));
            chk($sformatf("bp%0d ack", k), 32'({dsp_ack, cpu_ack, cmd_ack}), 32'b000);
            @(negedge clk);
        end
        drive(3'b001, 2'b00, 1'b1, 1'b0, 32'h0);
        #3; chk("bp release ack", 32'({dsp_ack, cpu_ack, cmd_ack}), 32'b001);
        @(negedge clk);
        drive(3'b000, 2'b00, 1'b1, 1'b1, 32'h0000ABCD);
        #3; chk("bp rdata", rdata, 32'h0000ABCD);
        @(negedge clk);

        // Three-way contention; each requester drops its request after its ack.
        do_reset();
        drive(3'b111, 2'b11, 1'b1, 1'b1, 32'h12345678);
        grants.delete();
        for (int k = 0; k < 20; k++) begin
            #3;
            if (dsp_ack) grants.push_back(0);
            if (cpu_ack) grants.push_back(1);
            if (cmd_ack) grants.push_back(2);
            @(negedge clk);
            if (dsp_ack) dsp_req = 1'b0;
            if (cpu_ack) cpu_req = 1'b0;
            if (cmd_ack) cmd_req = 1'b0;
        end
        chk("contend grant count", 32'(grants.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("contend grant%0d", k),
                (k < grants.size()) ? 32'(grants[k]) : 32'hFFFFFFFF, 32'(k));

        // CPU and command both held continuously for 8 write grants.
        do_reset();
        drive(3'b011, 2'b11, 1'b1, 1'b0, 32'h0);
        grants.delete();
        for (int k = 0; k < 40 && grants.size() < 8; k++) begin
            #3;
            if (cpu_ack) grants.push_back(1);
            if (cmd_ack) grants.push_back(2);
            @(negedge clk);
        end
        chk("fair grant count", 32'(grants.size()), 32'd8);
        n_cmd = 0;
        for (int k = 0; k < grants.size(); k++) begin
            if (grants[k] == 2) n_cmd++;
`ifdef VDP_VRAM_ARB_ROUND_ROBIN_EN
            chk($sformatf("fair grant%0d", k), 32'(grants[k]), 32'((k % 2) + 1));
`else
            chk($sformatf("fair grant%0d", k), 32'(grants[k]), 32'd1);
`endif
        end
`ifdef VDP_VRAM_ARB_ROUND_ROBIN_EN
        chk("fair cmd grants", 32'(n_cmd), 32'd4);
`else
        chk("fair cmd grants", 32'(n_cmd), 32'd0);
`endif

        // Reset while waiting for read data, then a stale mem_rdata_en.
        do_reset();
        drive(3'b001, 2'b00, 1'b1, 1'b0, 32'h0);
        @(negedge clk); #3;
        chk("rst ack", 32'(cmd_ack), 32'd1);
        @(negedge clk);
        drive(3'b000, 2'b00, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        #3;
        chk("rst mem_valid", 32'(mem_valid), 32'd0);
        chk("rst mem_address", 32'(mem_address), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(3'b000, 2'b00, 1'b1, 1'b1, 32'hBADBAD00);
        #3;
        chk("rst stale rdata_en", 32'({dsp_rdata_en, cpu_rdata_en, cmd_rdata_en}), 32'b000);
        chk("rst stale rdata", rdata, 32'h0);
        chk("rst stale mem_valid", 32'(mem_valid), 32'd0);
        @(negedge clk);
        drive(3'b010, 2'b10, 1'b1, 1'b0, 32'h0);
        @(negedge clk); #3;
        chk("rst next cpu_ack", 32'(cpu_ack), 32'd1);
        chk("rst next mem_address", 32'(mem_address), 32'(CPU_A));
        chk("rst next mem_wdata", 32'(mem_wdata), 32'hA5);
        @(negedge clk);
        drive(3'b000, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vdp_vram_arbiter.md
VDP_VRAM_ARBITER -- requirements
Module: vdp_vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, VRAM byte-address width.
REQ-002 SHALL have port clk input 1: single clock for all logic.
REQ-003 SHALL have port reset input 1: asynchronous, active-high.
REQ-004 SHALL have ports dsp_req/cpu_req/cmd_req input 1 each: level request from display, CPU port, command engine.
REQ-005 SHALL have ports dsp_address/cpu_address/cmd_address input ADDR_W each: target VRAM address.
REQ-006 SHALL have ports cpu_write/cmd_write input 1 and cpu_wdata/cmd_wdata input 8: write flag and write byte; display is read-only.
REQ-007 SHALL have ports dsp_ack/cpu_ack/cmd_ack output 1: one-cycle pulse when that request is accepted by memory.
REQ-008 SHALL have ports dsp_rdata_en/cpu_rdata_en/cmd_rdata_en output 1 and rdata output 32: read-data strobe per requester, shared data bus.
REQ-009 SHALL have ports mem_valid output 1, mem_ready input 1, mem_write output 1, mem_address output ADDR_W, mem_wdata output 8: memory request handshake.
REQ-010 SHALL have ports mem_rdata input 32, mem_rdata_en input 1: memory read return.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT_READ.
REQ-012 In IDLE with any req high, SHALL select a winner, latch its address/write/wdata and owner ID, and enter ISSUE next cycle with mem_valid=1.
REQ-013 Display SHALL always win over CPU and command when requesting in the same IDLE cycle.
REQ-014 Between CPU and command, selection SHALL follow REQ-027/REQ-028.
REQ-015 In ISSUE, mem_valid and latched outputs SHALL hold stable until mem_ready=1; on that cycle the owner's ack SHALL pulse for exactly one cycle.
REQ-016 Accepted write SHALL return to IDLE next cycle; accepted read SHALL enter WAIT_READ.
REQ-017 In WAIT_READ, on mem_rdata_en=1, rdata SHALL equal mem_rdata and only the owner's rdata_en SHALL pulse for one cycle, same cycle (combinational pass-through of data, registered owner); then IDLE.
REQ-018 mem_rdata_en outside WAIT_READ SHALL be ignored; no rdata_en asserted.
REQ-019 Requests changing or dropping after latch in REQ-012 SHALL NOT affect the in-flight transaction.
REQ-020 Requesters SHALL hold req until ack; arbiter SHALL treat req still high in the cycle after ack as a new request.
REQ-021 Minimum latency: req high in IDLE -> mem_valid next cycle -> ack same cycle as mem_ready; back-to-back write throughput 1 transaction per 2 cycles with mem_ready tied high.
REQ-022 Only one transaction SHALL be outstanding at any time; mem_valid SHALL be 0 in IDLE and WAIT_READ.
REQ-023 Address SHALL pass unmodified; no wrap or truncation within ADDR_W.

Reset
REQ-024 On reset: state IDLE, mem_valid=0, mem_write=0, mem_address=0, mem_wdata=0, all ack/rdata_en=0, rdata=0, round-robin pointer favours CPU.
REQ-025 Reset mid-ISSUE or mid-WAIT_READ SHALL abandon the transaction immediately; late mem_rdata_en after release SHALL be ignored per REQ-018.
REQ-026 First arbitration SHALL occur in the first clk edge after reset deasserts.

Configuration
REQ-027 With VDP_VRAM_ARB_ROUND_ROBIN_EN defined: CPU/command SHALL alternate; pointer toggles to the other requester after each accepted CPU or command transaction; a lone requester SHALL win regardless of pointer.
REQ-028 Without VDP_VRAM_ARB_ROUND_ROBIN_EN: fixed priority display > CPU > command; pointer logic absent.

Verification
REQ-029 Write: cpu_req, cpu_write=1, cpu_address=0x3F000, cpu_wdata=0x00, mem_ready=1 -> mem_valid one cycle later with address 0x3F000, data 0x00, cpu_ack single pulse, IDLE next cycle.
REQ-030 Read: cmd_req read 0x10000, mem_rdata=0x03020100 returned 5 cycles after ack -> cmd_rdata_en single pulse, rdata=0x03020100, no cpu/dsp_rdata_en.
REQ-031 Contention: dsp/cpu/cmd all request same cycle -> order dsp, then (RR) cpu, cmd; (fixed) cpu, cmd; each ack exactly once.
REQ-032 Backpressure: mem_ready low 10 cycles during ISSUE -> mem_valid and mem_address 0x10000 stable all 10 cycles, ack on cycle ready rises.
REQ-033 RR fairness (macro on): cpu and cmd held continuously for 8 transactions -> grants strictly alternate cpu,cmd,cpu...; (macro off) cmd receives 0 grants.
REQ-034 Reset in WAIT_READ, then mem_rdata_en pulse after reset -> no rdata_en, mem_valid=0, next request serviced normally.
